// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shared-multiplier sequencer.
// Holds the FSM encoding, partial-product shift table and operand helpers.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [5:0] SH_LL = 6'd0;
    localparam logic [5:0] SH_LH = 6'd16;
    localparam logic [5:0] SH_HL = 6'd16;
    localparam logic [5:0] SH_HH = 6'd32;

    localparam int MUL_LAT = 1;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        logic [31:0] m;
        if (is_signed && x[31]) begin
            m = ~x + 32'd1;
        end else begin
            m = x;
        end
        return m;
    endfunction

    function automatic logic [5:0] pp_shift(input logic [1:0] cnt);
        logic [5:0] sh;
        case (cnt)
            2'd0:    sh = SH_LL;
            2'd1:    sh = SH_LH;
            2'd2:    sh = SH_HL;
            default: sh = SH_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul16_cell.sv
// 16x16 unsigned multiplier with a single output register.
// Kept on its own so it maps onto one dedicated DSP block.
module mul16_cell (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] p_r;

    // Registered product; clear wins over enable
    always_ff @(posedge clk) begin
        if (clr) begin
            p_r <= 32'd0;
        end else if (en) begin
            p_r <= {16'd0, a} * {16'd0, b};
        end
    end

    assign p = p_r;

endmodule

// File: rtl/mul_seq_arbiter.sv
// Round-robin arbiter sequencing 32x32 signed/unsigned multiplies as four
// 16x16 partial products on one shared pipelined multiplier.
module mul_seq_arbiter
    import mul_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_signed,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [63:0]           resp_prod,
    output logic                  busy
);

    state_t               state_r;
    state_t               state_next_s;
    logic [1:0]           cnt_r;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      rr_next_s;
    logic [31:0]          a_mag_r;
    logic [31:0]          b_mag_r;
    logic                 neg_r;
    logic [ID_W-1:0]      id_r;
    logic [63:0]          acc_r;
    logic                 tag_valid_r;
    logic [5:0]           tag_sh_r;
    logic [63:0]          resp_prod_r;
    logic [ID_W-1:0]      resp_id_r;
    logic                 grant_found_s;
    logic [ID_W-1:0]      grant_id_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic [31:0]          sel_a_s;
    logic [31:0]          sel_b_s;
    logic                 sel_signed_s;
    logic [15:0]          mul_a_s;
    logic [15:0]          mul_b_s;
    logic [31:0]          mul_p_s;
    int                   idx_v;

    // Round-robin search from rr_ptr_r upward with wrap
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        idx_v         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_found_s && req_valid[idx_v]) begin
                grant_found_s = 1'b1;
                grant_id_s    = ID_W'(idx_v);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign rr_next_s    = (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
    assign sel_a_s      = req_a[int'(grant_id_s) * 32 +: 32];
    assign sel_b_s      = req_b[int'(grant_id_s) * 32 +: 32];
    assign sel_signed_s = req_signed[grant_id_s];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and combinational accept strobe
    always_comb begin
        state_next_s = state_r;
        req_ready_s  = '0;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_next_s            = ISSUE;
                    req_ready_s[grant_id_s] = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_r == 2'd3) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            DRAIN:   state_next_s = FIX;
            FIX:     state_next_s = DONE;
            DONE: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand latch, issue counter, pointer update and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= 2'd0;
            rr_ptr_r    <= '0;
            a_mag_r     <= 32'd0;
            b_mag_r     <= 32'd0;
            neg_r       <= 1'b0;
            id_r        <= '0;
            resp_prod_r <= 64'd0;
            resp_id_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        a_mag_r  <= mag32(sel_a_s, sel_signed_s);
                        b_mag_r  <= mag32(sel_b_s, sel_signed_s);
                        neg_r    <= sel_signed_s & (sel_a_s[31] ^ sel_b_s[31]);
                        id_r     <= grant_id_s;
                        rr_ptr_r <= rr_next_s;
                    end
                    cnt_r <= 2'd0;
                end
                ISSUE: cnt_r <= cnt_r + 2'd1;
                FIX: begin
                    resp_prod_r <= neg_r ? (~acc_r + 64'd1) : acc_r;
                    resp_id_r   <= id_r;
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // cnt bit 1 picks the A half, bit 0 the B half: LL, LH, HL, HH
    assign mul_a_s = cnt_r[1] ? a_mag_r[31:16] : a_mag_r[15:0];
    assign mul_b_s = cnt_r[0] ? b_mag_r[31:16] : b_mag_r[15:0];

    mul16_cell u_mul (
        .clk (clk),
        .clr (reset),
        .en  (state_r == ISSUE),
        .a   (mul_a_s),
        .b   (mul_b_s),
        .p   (mul_p_s)
    );

    // Tag pipe follows each product out of the multiplier register
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_r <= 1'b0;
            tag_sh_r    <= 6'd0;
            acc_r       <= 64'd0;
        end else begin
            tag_valid_r <= (state_r == ISSUE);
            tag_sh_r    <= pp_shift(cnt_r);
            if (state_r == IDLE) begin
                acc_r <= 64'd0;
            end else if (tag_valid_r) begin
                acc_r <= acc_r + (64'(mul_p_s) << tag_sh_r);
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = (state_r == DONE);
    assign resp_prod  = resp_prod_r;
    assign resp_id    = resp_id_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Scoreboard bench: accepts are observed and scored against arithmetic products,
// responses are popped and compared independently of the stimulus.
module tb_mul_seq_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_signed;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [63:0]           resp_prod;
    logic                  busy;

    mul_seq_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (s) r = sa * sb;
        else   r = ua * ub;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [63:0] prod;
        int          id;
        int          gcyc;
    } exp_t;

    exp_t        sb_q[$];
    int          model_ptr = 0;
    bit          inflight  = 1'b0;
    bit          in_resp   = 1'b0;
    int          grant_cyc = 0;
    logic [63:0] held_prod;
    logic [1:0]  held_id;
    int          last_grant_cyc = -1;
    int          last_grant_id  = -1;
    int          last_hs_cyc    = -1;
    logic [63:0] last_hs_prod;
    int          last_hs_id     = -1;

    // Monitor: scores accepts against the round-robin rule and checks responses
    always @(negedge clk) begin
        int   g;
        int   act_g;
        int   idx;
        exp_t e;
        if (reset) begin
            sb_q.delete();
            model_ptr = 0;
            inflight  = 1'b0;
            in_resp   = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(inflight));
            if (inflight) begin
                chk("ready_outside_idle", 64'(req_ready), 64'd0);
                if (!in_resp && !resp_valid && (cyc - grant_cyc) > 7) begin
                    chk("resp_timeout", 64'(resp_valid), 64'd1);
                    inflight = 1'b0;
                    sb_q.delete();
                end
            end else if (req_valid != '0) begin
                g = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (model_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                chk("grant", 64'(req_ready), 64'(4'b0001 << g));
                act_g = -1;
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) act_g = k;
                e.prod = ref_mul(req_a[32*g +: 32], req_b[32*g +: 32], req_signed[g]);
                e.id   = g;
                e.gcyc = cyc;
                sb_q.push_back(e);
                model_ptr      = (g + 1) % NUM_REQ;
                inflight       = 1'b1;
                grant_cyc      = cyc;
                last_grant_cyc = cyc;
                last_grant_id  = act_g;
            end else begin
                chk("no_grant", 64'(req_ready), 64'd0);
            end

            if (resp_valid) begin
                if (!in_resp) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp: actual id=%0d prod=%h required no response", resp_id, resp_prod);
                    end else begin
                        e = sb_q.pop_front();
                        chk("resp_prod", resp_prod, e.prod);
                        chk("resp_id", 64'(resp_id), 64'(e.id));
                        chk("latency", 64'(cyc - e.gcyc), 64'd7);
                    end
                    in_resp   = 1'b1;
                    held_prod = resp_prod;
                    held_id   = resp_id;
                end else begin
                    chk("hold_prod", resp_prod, held_prod);
                    chk("hold_id", 64'(resp_id), 64'(held_id));
                end
                if (resp_ready) begin
                    in_resp      = 1'b0;
                    inflight     = 1'b0;
                    last_hs_cyc  = cyc;
                    last_hs_prod = resp_prod;
                    last_hs_id   = int'(resp_id);
                end
            end else if (in_resp) begin
                chk("resp_dropped", 64'(resp_valid), 64'd1);
                in_resp = 1'b0;
            end
        end
    end

    task automatic wait_grant(output int g, output int c);
        int seen;
        seen = last_grant_cyc;
        g = -1;
        c = -1;
        for (int n = 0; n < 64 && g < 0; n++) begin
            @(posedge clk);
            #1;
            if (last_grant_cyc != seen) begin
                g = last_grant_id;
                c = last_grant_cyc;
            end
        end
        if (g < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_wait: actual no accept in 64 cycles, required an accept");
        end
    endtask

    task automatic wait_hs();
        int  seen;
        bit  got;
        seen = last_hs_cyc;
        got  = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(posedge clk);
            #1;
            if (last_hs_cyc != seen) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL resp_wait: actual no response in 64 cycles, required a response");
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_signed[idx]     = s;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] expv, input string nm);
        int g;
        int c;
        @(posedge clk);
        #1;
        set_req(idx, a, b, s);
        wait_grant(g, c);
        req_valid[idx] = 1'b0;
        chk({nm, "_gid"}, 64'(g), 64'(idx));
        wait_hs();
        chk({nm, "_prod"}, last_hs_prod, expv);
        chk({nm, "_id"}, 64'(last_hs_id), 64'(idx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int c;
        int prev_c;
        int hc;
        int seen_g;
        int nresp;
        bit got;

        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_prod", resp_prod, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Directed products; requesters 0..3 in turn leave the pointer at 0
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
        do_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, "umix");
        do_op(2, 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "sneg");
        do_op(3, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "smin");

        // Round robin with every requester asserted
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        prev_c = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, c);
            if (k == 4) req_valid = '0;
            chk("rr_order", 64'(g), 64'(k % NUM_REQ));
            if (k > 0) chk("rr_spacing", 64'(c - prev_c), 64'd8);
            prev_c = c;
        end
        wait_hs();

        do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "sone");

        // Backpressure in DONE with another requester waiting
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        set_req(0, 32'hDEAD_BEEF, 32'h0001_0003, 1'b0);
        wait_grant(g, c);
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (resp_valid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("bp_resp_seen", 64'(got), 64'd1);
        set_req(3, 32'd9, 32'd11, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        hc = cyc;
        @(posedge clk);
        #1;
        chk("bp_release", 64'(last_hs_cyc), 64'(hc));
        wait_grant(g, c);
        req_valid[3] = 1'b0;
        chk("bp_next_gid", 64'(g), 64'd3);
        wait_hs();

        // Reset in the third cycle after accept
        @(posedge clk);
        #1;
        set_req(1, rand_op(), rand_op(), 1'b0);
        wait_grant(g, c);
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        nresp = 0;
        for (int n = 0; n < 12; n++) begin
            if (resp_valid) nresp++;
            @(negedge clk);
        end
        chk("post_rst_no_resp", 64'(nresp), 64'd0);
        do_op(2, 32'd5, 32'd6, 1'b0, 64'd30, "post_rst");

        // Random traffic with random backpressure
        seen_g = last_grant_cyc;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (last_grant_cyc != seen_g) begin
                req_valid[last_grant_id] = 1'b0;
                seen_g = last_grant_cyc;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (20) @(posedge clk);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_seq_arbiter.md
# mul_seq_arbiter

Shared-multiplier sequencer for the ray-tracing fixed-point datapath. It arbitrates up to NUM_REQ requesters round-robin onto a single pipelined 16x16 unsigned multiplier. Each 32x32 request is sequenced as four partial products, which are accumulated into a 64-bit signed or unsigned result. The block sits between the custom ray/intersection units and one dedicated DSP multiplier, so several units share one hard multiplier block.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of the requester index

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  NUM_REQ*32  operand A, requester i at bits [32i+31:32i]
- req_b  in  NUM_REQ*32  operand B, same packing as req_a
- req_signed  in  NUM_REQ  1 = two's-complement operands, 0 = unsigned
- req_ready  out  NUM_REQ  one-hot accept strobe
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_id  out  ID_W  index of the requester that owns the result
- resp_prod  out  64  full product
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FIX, DONE.
- **IDLE**
  - Scan req_valid starting at rr_ptr, increasing with wrap, and pick the first set bit g.
  - req_ready[g]=1 combinationally in the same cycle; this is the handshake.
  - Latch |a|, |b|, neg = signed & (a[31]^b[31]), id=g.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Clear acc; go to ISSUE with cnt=0.
- **ISSUE** (cnt 0..3): drive the multiplier with the following pairs.
  - cnt 0: a_lo,b_lo
  - cnt 1: a_lo,b_hi
  - cnt 2: a_hi,b_lo
  - cnt 3: a_hi,b_hi
  - A tag pipe (valid + shift) travels with each product.
  - When cnt==3, go to DRAIN.
- **Accumulation**
  - Each returning product is zero-extended to 64 bits, shifted left by 0/16/16/32 respectively, and added to acc (64-bit, no overflow possible).
  - Products issued at cnt 0..3 are accumulated in ISSUE cnt1..3 and in DRAIN.
- **DRAIN**: the final product is accumulated; go to FIX.
- **FIX**: resp_prod <= neg ? (~acc+1) : acc; resp_id <= id; go to DONE.
- **DONE**
  - resp_valid=1; resp_prod and resp_id are held stable.
  - When resp_ready=1, go to IDLE. No new grant is issued in this same cycle.
- **Operand magnitude**
  - |x| = x[31] ? (~x+1) : x, applied only when signed.
  - 0x80000000 yields 0x80000000 as 32-bit unsigned, which is correct.
- **Outputs outside their states**
  - req_ready is all-zero outside IDLE.
  - A requester whose req_valid is low is never granted.
  - Requesters may drop req_valid at any time before they are granted; no state change results.
- **Reset**
  - Reset at any point, including mid-ISSUE or in DONE, forces IDLE.
  - rr_ptr=0, acc=0, multiplier register=0, tag pipe cleared.
  - Any in-flight operation is discarded and no response is produced.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_prod=0, busy=0.
- Accept occurs in cycle T (IDLE, req_ready[g]=1).
- ISSUE runs T+1..T+4, DRAIN T+5, FIX T+6.
- resp_valid rises in T+7. Accept-to-response latency is 7 cycles.
- Multiplier latency is exactly 1 cycle (registered product).
- With resp_ready held high, throughput is one operation per 8 cycles; the next grant is earliest at T+8.
- Backpressure: DONE holds for any number of cycles; all outputs are stable and req_ready=0.

## Structure
- Shared package mul_seq_pkg holds:
  - state enum
  - partial-product select/shift constants (SH_LL=0, SH_LH=16, SH_HL=16, SH_HH=32)
  - MUL_LAT=1
- Sub-module mul16_cell:
  - 16x16 unsigned multiplier, one output register, enable, synchronous clear.
  - Isolated so that it maps to one dedicated DSP multiplier.
- Arbiter and sequencer logic live in the top module.

## Test plan
- **Unsigned maximum:** req 0 unsigned 0xFFFFFFFF × 0xFFFFFFFF -> resp_prod=0xFFFFFFFE00000001, resp_id=0, resp_valid exactly 7 cycles after req_ready[0].
- **Unsigned mixed:** unsigned 0x12345678 × 0x9ABCDEF0 -> 0x0B00EA4E242D2080.
- **Signed:**
  - -3 × 7 -> 0xFFFFFFFFFFFFFFEB
  - 0x80000000 × 0x80000000 -> 0x4000000000000000
  - -1 × -1 -> 0x1
- **Round robin:** all four req_valid held high with resp_ready=1 -> grant order 0,1,2,3,0, each grant 8 cycles apart, resp_id matches.
- **Backpressure:** resp_ready low for 5 cycles in DONE -> resp_valid, resp_prod and resp_id stable, req_ready=0; the response completes on the first resp_ready=1 cycle.
- **Reset mid-operation:** reset asserted for 1 cycle at T+3 -> no resp_valid, busy=0 after reset, rr_ptr=0. A following request from req 2 (5 × 6 unsigned) returns 30 with resp_id=2.
